// File: rtl/beat_sequencer.sv
// ============================================================================
// beat_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Beat index generator for a game sound engine. One music channel follows the
//   game state (MENU and GAME songs loop, GAMEOVER plays once and holds on its
//   last beat). An optional collision sound-effect channel runs independently
//   of the music and of pause.
//
// Build option:
//   BEAT_SEQUENCER_SFX_EN - when defined, the collision effect channel is
//   built. When undefined, sfx_active/sfx_beat are tied to 0, collision_trig is
//   ignored and no effect flops exist. Music behaviour is the same either way.
//
// Parameters:
//   LEN_MENU, LEN_GAME, LEN_OVER, LEN_SFX - beat counts (1 .. 2**BEAT_W)
//   BEAT_W                                - width of the beat counters
//
// Ports:
//   clk            in   system clock (single domain)
//   reset          in   asynchronous active-high reset
//   beat_en        in   one-clock beat strobe; counters advance only with it
//   state[2:0]     in   game state: 0 MENU, 1 GAME, 2 GAMEOVER, 3-7 silent
//   pause          in   freezes the music channel (not the effect)
//   collision_trig in   level input; a rising edge starts the effect
//   ibeat          out  current music beat index
//   song_sel[2:0]  out  registered state that ibeat belongs to
//   music_on       out  song_sel is 0-2 and the song is not finished
//   done           out  GAMEOVER is held on its last beat
//   sfx_beat       out  current effect beat index
//   sfx_active     out  effect playing (takes priority in the tone muxes)
// ============================================================================
module beat_sequencer #(
    parameter int LEN_MENU = 512,
    parameter int LEN_GAME = 1024,
    parameter int LEN_OVER = 128,
    parameter int LEN_SFX  = 16,
    parameter int BEAT_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat_en,
    input  logic [2:0]        state,
    input  logic              pause,
    input  logic              collision_trig,
    output logic [BEAT_W-1:0] ibeat,
    output logic [2:0]        song_sel,
    output logic              music_on,
    output logic              done,
    output logic [BEAT_W-1:0] sfx_beat,
    output logic              sfx_active
);

    // Last beat index of each song; LEN == 2**BEAT_W gives an all-ones value,
    // and the natural counter overflow then produces the wrap to 0.
    localparam logic [BEAT_W-1:0] LAST_MENU = BEAT_W'(LEN_MENU - 1);
    localparam logic [BEAT_W-1:0] LAST_GAME = BEAT_W'(LEN_GAME - 1);
    localparam logic [BEAT_W-1:0] LAST_OVER = BEAT_W'(LEN_OVER - 1);
    localparam logic [BEAT_W-1:0] ONE       = BEAT_W'(1);

    // ------------------------------------------------------------------------
    // Music channel
    // ------------------------------------------------------------------------
    logic [2:0]        song_sel_q;
    logic [BEAT_W-1:0] ibeat_q, ibeat_d;
    logic              done_q, done_d;

    always_comb begin
        ibeat_d = ibeat_q;
        done_d  = done_q;
        if (state != song_sel_q) begin
            // A new song always starts at beat 0, even between beat strobes
            // and while paused.
            ibeat_d = '0;
            done_d  = 1'b0;
        end else if (song_sel_q > 3'd2) begin
            ibeat_d = '0;
            done_d  = 1'b0;
        end else if (beat_en && !pause) begin
            case (song_sel_q)
                3'd0:    ibeat_d = (ibeat_q == LAST_MENU) ? '0 : ibeat_q + ONE;
                3'd1:    ibeat_d = (ibeat_q == LAST_GAME) ? '0 : ibeat_q + ONE;
                default: begin
                    // GAMEOVER is one-shot: climb to the last beat and park
                    // there; done rises on the beat that lands on it.
                    ibeat_d = (ibeat_q == LAST_OVER) ? ibeat_q : ibeat_q + ONE;
                    done_d  = (ibeat_d == LAST_OVER);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            song_sel_q <= 3'd0;
            ibeat_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            song_sel_q <= state;
            ibeat_q    <= ibeat_d;
            done_q     <= done_d;
        end
    end

    assign ibeat    = ibeat_q;
    assign song_sel = song_sel_q;
    assign done     = done_q;
    // Derived from registered state only, so it holds naturally under pause
    // and reads 1 out of reset (MENU, not finished).
    assign music_on = (song_sel_q <= 3'd2) && !done_q;

    // ------------------------------------------------------------------------
    // Collision effect channel
    // ------------------------------------------------------------------------
`ifdef BEAT_SEQUENCER_SFX_EN
    localparam logic [BEAT_W-1:0] LAST_SFX = BEAT_W'(LEN_SFX - 1);

    logic              trig_q;
    logic              trig_edge;
    logic              sfx_active_q, sfx_active_d;
    logic [BEAT_W-1:0] sfx_beat_q, sfx_beat_d;

    assign trig_edge = collision_trig && !trig_q;

    always_comb begin
        sfx_active_d = sfx_active_q;
        sfx_beat_d   = sfx_beat_q;
        // A new edge restarts the effect and overrides a terminal-beat clear
        // landing on the same edge.
        if (trig_edge) begin
            sfx_active_d = 1'b1;
            sfx_beat_d   = '0;
        end else if (sfx_active_q && beat_en) begin
            if (sfx_beat_q == LAST_SFX) begin
                sfx_active_d = 1'b0;
                sfx_beat_d   = '0;
            end else begin
                sfx_beat_d   = sfx_beat_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q       <= 1'b0;
            sfx_active_q <= 1'b0;
            sfx_beat_q   <= '0;
        end else begin
            trig_q       <= collision_trig;
            sfx_active_q <= sfx_active_d;
            sfx_beat_q   <= sfx_beat_d;
        end
    end

    assign sfx_active = sfx_active_q;
    assign sfx_beat   = sfx_beat_q;
`else
    logic sfx_unused;
    assign sfx_unused = collision_trig;
    assign sfx_active = 1'b0;
    assign sfx_beat   = '0;
`endif

endmodule

// File: tb/tb_beat_sequencer.sv
module tb_beat_sequencer;

    localparam int BW = 8;

`ifdef BEAT_SEQUENCER_SFX_EN
    localparam bit SFX_EN = 1'b1;
`else
    localparam bit SFX_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          beat_en;
    logic [2:0]    state;
    logic          pause;
    logic          collision_trig;

    logic [BW-1:0] ibeat, sfx_beat;
    logic [2:0]    song_sel;
    logic          music_on, done, sfx_active;

    logic [BW-1:0] u1_ibeat, u1_sfx_beat_unused;
    logic [2:0]    u1_song_sel;
    logic          u1_music_on, u1_done, u1_sfx_active_unused;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    beat_sequencer #(
        .LEN_MENU(4), .LEN_GAME(128), .LEN_OVER(3), .LEN_SFX(4), .BEAT_W(BW)
    ) dut (
        .clk(clk), .reset(reset), .beat_en(beat_en), .state(state),
        .pause(pause), .collision_trig(collision_trig),
        .ibeat(ibeat), .song_sel(song_sel), .music_on(music_on), .done(done),
        .sfx_beat(sfx_beat), .sfx_active(sfx_active)
    );

    // All lengths 1: counters pinned at 0, GAMEOVER done after the first beat.
    beat_sequencer #(
        .LEN_MENU(1), .LEN_GAME(1), .LEN_OVER(1), .LEN_SFX(1), .BEAT_W(BW)
    ) dut1 (
        .clk(clk), .reset(reset), .beat_en(beat_en), .state(state),
        .pause(pause), .collision_trig(collision_trig),
        .ibeat(u1_ibeat), .song_sel(u1_song_sel), .music_on(u1_music_on),
        .done(u1_done), .sfx_beat(u1_sfx_beat_unused),
        .sfx_active(u1_sfx_active_unused)
    );

    typedef struct {
        int   ib;
        int   sel;
        logic mon;
        logic dn;
        int   sb;
        logic sa;
        int   u1d;   // -1: second instance not checked
        int   tag;
    } exp_t;

    exp_t exp_q[$];
    logic probe_t = 1'b0;
    int   tag_n   = 0;

    task automatic chk(input string n, input int tag, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s (vec %0d) actual=%0d required=%0d", n, tag, act, req);
        end
    endtask

    // Monitor: compares every pending expectation on each negedge, or
    // immediately when the stimulus toggles probe_t (asynchronous checks).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or probe_t);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ibeat",      e.tag, int'(ibeat),      e.ib);
                chk("song_sel",   e.tag, int'(song_sel),   e.sel);
                chk("music_on",   e.tag, int'(music_on),   int'(e.mon));
                chk("done",       e.tag, int'(done),       int'(e.dn));
                chk("sfx_beat",   e.tag, int'(sfx_beat),   e.sb);
                chk("sfx_active", e.tag, int'(sfx_active), int'(e.sa));
                if (e.u1d >= 0) begin
                    chk("len1_ibeat",    e.tag, int'(u1_ibeat),    0);
                    chk("len1_song_sel", e.tag, int'(u1_song_sel), e.sel);
                    chk("len1_done",     e.tag, int'(u1_done),     e.u1d);
                    chk("len1_music_on", e.tag, int'(u1_music_on),
                        ((e.sel <= 2) && (e.u1d == 0)) ? 1 : 0);
                end
            end
        end
    end

    task automatic push(input int eb, input int es, input logic em, input logic ed,
                        input int esb, input logic esa, input int u1d);
        exp_t e;
        e.ib  = eb;
        e.sel = es;
        e.mon = em;
        e.dn  = ed;
        e.sb  = SFX_EN ? esb : 0;
        e.sa  = SFX_EN ? esa : 1'b0;
        e.u1d = u1d;
        e.tag = tag_n;
        tag_n++;
        exp_q.push_back(e);
    endtask

    // Drive one clock of inputs, then record the outputs expected after the edge.
    task automatic step(input logic be, input logic [2:0] st, input logic pa,
                        input logic tr, input int eb, input int es, input logic em,
                        input logic ed, input int esb, input logic esa, input int u1d);
        beat_en        = be;
        state          = st;
        pause          = pa;
        collision_trig = tr;
        @(posedge clk);
        #1;
        push(eb, es, em, ed, esb, esa, u1d);
        beat_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; beat_en = 1'b0; state = 3'd0; pause = 1'b0; collision_trig = 1'b0;
        #2;
        push(0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
        probe_t = ~probe_t;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // MENU loop, LEN_MENU=4
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, -1);
        step(1, 0, 0, 0, 3, 0, 1, 0, 0, 0, -1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, -1);
        step(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);

        // State change with no beat strobe
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, -1);
        for (int i = 1; i <= 10; i++) step(1, 1, 0, 0, i, 1, 1, 0, 0, 0, -1);

        // Pause freezes music, effect keeps going
        step(0, 1, 0, 1, 10, 1, 1, 0, 0, 1, -1);
        step(1, 1, 1, 1, 10, 1, 1, 0, 1, 1, -1);
        step(1, 1, 1, 1, 10, 1, 1, 0, 2, 1, -1);
        step(1, 1, 1, 1, 10, 1, 1, 0, 3, 1, -1);
        step(1, 1, 0, 0, 11, 1, 1, 0, 0, 0, -1);

        // Retrigger on a beat edge
        step(0, 1, 0, 1, 11, 1, 1, 0, 0, 1, -1);
        step(1, 1, 0, 1, 12, 1, 1, 0, 1, 1, -1);
        step(1, 1, 0, 1, 13, 1, 1, 0, 2, 1, -1);
        step(0, 1, 0, 0, 13, 1, 1, 0, 2, 1, -1);
        step(1, 1, 0, 1, 14, 1, 1, 0, 0, 1, -1);
        step(1, 1, 0, 1, 15, 1, 1, 0, 1, 1, -1);
        step(1, 1, 0, 1, 16, 1, 1, 0, 2, 1, -1);
        step(1, 1, 0, 1, 17, 1, 1, 0, 3, 1, -1);
        step(1, 1, 0, 1, 18, 1, 1, 0, 0, 0, -1);

        // Trigger edge coinciding with the terminal beat
        step(0, 1, 0, 0, 18, 1, 1, 0, 0, 0, -1);
        step(0, 1, 0, 1, 18, 1, 1, 0, 0, 1, -1);
        step(1, 1, 0, 1, 19, 1, 1, 0, 1, 1, -1);
        step(1, 1, 0, 1, 20, 1, 1, 0, 2, 1, -1);
        step(1, 1, 0, 1, 21, 1, 1, 0, 3, 1, -1);
        step(0, 1, 0, 0, 21, 1, 1, 0, 3, 1, -1);
        step(1, 1, 0, 1, 22, 1, 1, 0, 0, 1, -1);
        step(1, 1, 0, 0, 23, 1, 1, 0, 1, 1, -1);

        // GAMEOVER one-shot, effect carried across the state change
        step(0, 2, 0, 0, 0, 2, 1, 0, 1, 1, 0);
        step(1, 2, 0, 0, 1, 2, 1, 0, 2, 1, 1);
        step(1, 2, 0, 0, 2, 2, 0, 1, 3, 1, 1);
        step(1, 2, 0, 0, 2, 2, 0, 1, 0, 0, -1);
        step(1, 2, 0, 0, 2, 2, 0, 1, 0, 0, -1);
        step(1, 2, 0, 0, 2, 2, 0, 1, 0, 0, -1);
        step(1, 2, 1, 0, 2, 2, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Silent states
        step(1, 5, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 5, 0, 0, 0, 0, -1);
        step(1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0);

        // GAME up to beat 100 with the effect active, then reset
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, -1);
        for (int i = 1; i <= 99; i++) step(1, 1, 0, 0, i, 1, 1, 0, 0, 0, -1);
        step(1, 1, 0, 1, 100, 1, 1, 0, 0, 1, -1);

        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        push(0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
        probe_t = ~probe_t;
        #1;
        step(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, -1);
        step(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, -1);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
